// File: rtl/alu_accumulator_seq.sv
// Sequential ALU with accumulator feedback: operand B is the low half of the
// registered result. Single-cycle logic/arith ops plus a WIDTH-cycle
// shift-add multiplier guarded by a start/busy/done handshake.
module alu_accumulator_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [2:0]           Function,
  input  logic [WIDTH-1:0]     A,
  output logic [2*WIDTH-1:0]   ALUout,
  output logic                 busy,
  output logic                 done,
  output logic                 zero
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    alu_q, alu_d;
  logic [RW-1:0]    prod_q, prod_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b;
  logic [RW-1:0]    a_ext, b_ext, op_res, prod_sum;

  assign b     = alu_q[WIDTH-1:0];
  assign a_ext = {{WIDTH{1'b0}}, A};
  assign b_ext = {{WIDTH{1'b0}}, b};

  // Result of every single-cycle op; hold (111) and multiply fall back to the current value
  always_comb begin
    op_res = alu_q;
    case (Function)
      3'b000:  op_res = a_ext - b_ext;
      3'b001:  op_res = a_ext + b_ext;
      3'b010:  op_res = {~(A | b), ~(A & b)};
      3'b011:  op_res = (|A || |b) ? {2'b11, {(RW-2){1'b0}}} : '0;
      3'b101:  op_res = {b, ~A};
      3'b110:  op_res = {A ^ b, ~(A ^ b)};
      default: op_res = alu_q;
    endcase
  end

  // Next-state logic: accept in IDLE, one shift-add step per cycle in MUL
  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (Function == 3'b100) begin
            state_d  = MUL;
            prod_d   = '0;
            mcand_d  = a_ext;
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
          end else begin
            alu_d  = op_res;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last step: the product goes straight to the result register
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          alu_d   = prod_sum;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over everything, including an in-flight multiply
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      alu_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign ALUout = alu_q;
  assign busy   = (state_q == MUL);
  assign done   = done_q;
  assign zero   = (alu_q == '0);

endmodule

// File: tb/tb_alu_accumulator_seq.sv
// Scoreboard bench: a behavioural model pushes each expected result at the
// edge the op completes; a negedge monitor pops on done and compares.
module tb_alu_accumulator_seq;
  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   Function = 3'b000;
  logic [W-1:0] A = '0;
  logic [2*W-1:0] ALUout;
  logic         busy, done, zero;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  alu_accumulator_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .Function(Function), .A(A),
    .ALUout(ALUout), .busy(busy), .done(done), .zero(zero)
  );

  always #5 Clock = ~Clock;

  // Reference model state
  int          acc_m = 0;   // expected ALUout
  int          pend  = 0;   // remaining multiply cycles
  int          mres  = 0;
  int          exp_q[$];

  function automatic int ref_op(input int f, input int a, input int bb, input int cur);
    int r;
    case (f)
      0: r = (a - bb) & 8'hFF;
      1: r = a + bb;
      2: r = ((~(a | bb) & 15) << 4) | (~(a & bb) & 15);
      3: r = (a != 0 || bb != 0) ? 8'hC0 : 0;
      5: r = (bb << 4) | (~a & 15);
      6: r = ((a ^ bb) << 4) | (~(a ^ bb) & 15);
      default: r = cur;
    endcase
    return r;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      acc_m = 0; pend = 0; exp_q.delete();
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin acc_m = mres; exp_q.push_back(acc_m); end
    end else if (start) begin
      if (Function == 3'd4) begin
        mres = int'(A) * (acc_m % 16);
        pend = W;
      end else begin
        acc_m = ref_op(int'(Function), int'(A), acc_m % 16, acc_m);
        exp_q.push_back(acc_m);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: done must coincide with a pending expected result
  always @(negedge Clock) begin
    if (mon_en) begin
      chk("done", int'(done), int'(exp_q.size() != 0));
      if (done && exp_q.size() != 0) chk("result", int'(ALUout), exp_q.pop_front());
      else exp_q.delete();
      chk("hold", int'(ALUout), acc_m);
      chk("busy", int'(busy), int'(pend > 0));
      chk("zero", int'(zero), int'(acc_m == 0));
    end
  end

  task automatic tick(); @(posedge Clock); #1; endtask

  task automatic do_reset();
    Reset = 1; start = 0; tick(); Reset = 0;
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a);
    start = 1; Function = f; A = a; tick(); start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) return;
      tick();
    end
    chk("busy_timeout", int'(busy), 0);
  endtask

  initial begin
    tick(); tick();
    Reset = 0;
    mon_en = 1;
    #1;
    chk("rst_out", int'(ALUout), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_busy", int'(busy), 0);

    // reset and add feedback
    do_reset();
    chk("r_out", int'(ALUout), 8'h00);
    issue(3'b001, 4'd3); chk("add3", int'(ALUout), 8'h03); chk("add3_done", int'(done), 1);
    issue(3'b001, 4'd5); chk("add5", int'(ALUout), 8'h08);
    issue(3'b001, 4'd9); chk("add9", int'(ALUout), 8'h11); chk("add9_zero", int'(zero), 0);

    // subtract wrap, concat
    do_reset(); issue(3'b001, 4'd5);
    issue(3'b000, 4'd2); chk("sub", int'(ALUout), 8'hFD);
    issue(3'b101, 4'd0); chk("cat", int'(ALUout), 8'hDF);

    // logic ops
    do_reset(); issue(3'b001, 4'd5);
    issue(3'b010, 4'hA); chk("nornand", int'(ALUout), 8'h0F);
    issue(3'b110, 4'h3); chk("xorxnor", int'(ALUout), 8'hC3);
    do_reset();
    issue(3'b011, 4'd0); chk("any0", int'(ALUout), 8'h00); chk("any0_zero", int'(zero), 1);
    issue(3'b011, 4'd1); chk("any1", int'(ALUout), 8'hC0);

    // multiply 6*7, busy exactly WIDTH cycles with ALUout held
    do_reset(); issue(3'b001, 4'd7);
    issue(3'b100, 4'd6);
    for (int i = 0; i < W; i++) begin
      chk("mul_busy", int'(busy), 1);
      chk("mul_hold", int'(ALUout), 8'h07);
      chk("mul_nodone", int'(done), 0);
      tick();
    end
    chk("mul_res", int'(ALUout), 8'h2A); chk("mul_done", int'(done), 1); chk("mul_idle", int'(busy), 0);
    tick(); chk("mul_done1", int'(done), 0);

    // 15*15
    do_reset(); issue(3'b001, 4'hF);
    issue(3'b100, 4'hF); wait_idle(); chk("mulff", int'(ALUout), 8'hE1);

    // ignored start during multiply, then hold
    do_reset(); issue(3'b001, 4'd7);
    issue(3'b100, 4'd6);
    issue(3'b001, 4'd3);
    wait_idle(); chk("ign_res", int'(ALUout), 8'h2A);
    issue(3'b111, 4'd5); chk("hold_res", int'(ALUout), 8'h2A); chk("hold_done", int'(done), 1);

    // reset mid-multiply
    do_reset(); issue(3'b001, 4'd7);
    issue(3'b100, 4'd6);
    tick();
    Reset = 1; tick(); Reset = 0;
    chk("abort_out", int'(ALUout), 0); chk("abort_busy", int'(busy), 0); chk("abort_done", int'(done), 0);
    repeat (6) tick();
    issue(3'b001, 4'd4); chk("post_abort", int'(ALUout), 8'h04);

    // random traffic, scoreboard does the checking
    for (int i = 0; i < 1500; i++) begin
      Reset    = ($urandom_range(0, 79) == 0);
      start    = $urandom_range(0, 2) != 0;
      Function = 3'($urandom_range(0, 7));
      A        = W'($urandom);
      tick();
    end
    Reset = 0; start = 0;
    repeat (W + 2) tick();
    mon_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
